bcd_sequence_monitor: RTL and testbench
=======================================

BCD_SEQUENCE_MONITOR -- requirements
Module: bcd_sequence_monitor

Interface
REQ-001 The block SHALL use a single clock and reset: reset is asynchronous and active-high, and the ports SHALL be named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 count_in  input  4  BCD digit from a bouncing 0..9..0 up/down counter.
REQ-005 valid_in  input  1  count_in is sampled on an edge only when valid_in=1.
REQ-006 locked  output  1  high while the sequence is tracked (LOCK_UP or LOCK_DOWN).
REQ-007 dir  output  1  tracked direction: 0=up, 1=down; holds its last value when not locked.
REQ-008 err  output  1  one-cycle pulse on a rejected sample.
REQ-009 err_code  output  2  cause of last error: 01 non-BCD, 10 wrong step, 11 illegal dwell; holds until next error.
REQ-010 turn_cnt  output  8  count of turnarounds seen while locked; saturates at 255.
REQ-011 err_cnt  output  8  count of err pulses; saturates at 255.

Function
REQ-012 Legal stream SHALL be: 0,1,...,9,9,8,...,1,0,0,1,... (single dwell at each extreme, then reverse).
REQ-013 FSM states SHALL be ACQUIRE, SYNC, LOCK_UP, LOCK_DOWN; a 4-bit prev register holds the last accepted sample.
REQ-014 With valid_in=0 all state, prev and outputs SHALL hold, and err SHALL be 0.
REQ-015 All outputs SHALL be registered and update on the same edge that samples a valid count_in (1-cycle latency).
REQ-016 Any count_in>9: err=1, code 01, next state ACQUIRE, prev unchanged; this rule overrides all others.
REQ-017 ACQUIRE, BCD sample: prev<=sample, go to SYNC, no error.
REQ-018 SYNC: sample=prev+1 -> LOCK_UP; sample=prev-1 -> LOCK_DOWN.
REQ-019 SYNC: sample=prev=9 -> LOCK_DOWN; sample=prev=0 -> LOCK_UP.
REQ-020 SYNC: any other sample -> err, code 10 (or 11 if sample=prev), stay SYNC; turn_cnt SHALL NOT increment from SYNC.
REQ-021 LOCK_UP: sample=prev+1 with prev<9 -> stay in LOCK_UP.
REQ-022 LOCK_UP: prev=9 and sample=9 -> LOCK_DOWN, dir<=1, turn_cnt+1.
REQ-023 LOCK_DOWN: sample=prev-1 with prev>0 -> stay in LOCK_DOWN.
REQ-024 LOCK_DOWN: prev=0 and sample=0 -> LOCK_UP, dir<=0, turn_cnt+1.
REQ-025 Locked: sample=prev outside REQ-022/024 (including a second dwell) -> err code 11; any other step -> err code 10.
REQ-026 Locked error (REQ-025): go to SYNC, locked<=0, dir held.
REQ-027 prev SHALL update to every valid BCD sample, including error samples (resync point).
REQ-028 On entering a locked state, dir SHALL be set to match it (LOCK_UP=0, LOCK_DOWN=1).
REQ-029 err_cnt SHALL increment on every err pulse; turn_cnt and err_cnt SHALL both stop at 255 with no wrap.

Reset
REQ-030 While reset=1, regardless of clk: state=ACQUIRE, prev=0, locked=0, dir=0, err=0, err_code=00, turn_cnt=0, err_cnt=0.
REQ-031 Reset asserted mid-stream SHALL take effect immediately; the first valid sample after release is treated as in ACQUIRE.

Verification
REQ-032 Feed 0,1,..,9,9,8,..,0,0,1 -> locked=1 after 2nd sample, dir 0->1 at second 9, 1->0 at second 0, turn_cnt=2, err_cnt=0.
REQ-033 Locked up at 5, inject 7 -> err pulse, code 10, locked=0, state SYNC; then 8,9 -> relocked up, err_cnt=1.
REQ-034 Locked up, feed 9,9,9 -> third 9 gives err code 11, state SYNC; then 8 -> LOCK_DOWN, dir=1.
REQ-035 Inject 4'hC while locked -> err code 01, state ACQUIRE, locked=0; then 3,4 -> LOCK_UP after 2 samples.
REQ-036 Toggle valid_in=0 for 5 cycles mid-stream -> no output change; stream resumes without error.
REQ-037 Force 256 turnarounds -> turn_cnt stays 255; assert reset mid-count -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/bcd_sequence_monitor.sv
// bcd_sequence_monitor: tracks a BCD digit stream that bounces 0..9..0 with a
// single dwell at each extreme, reports lock/direction, flags rejected samples
// with a cause code, and counts turnarounds and errors (both saturating).
module bcd_sequence_monitor (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count_in,
    input  logic       valid_in,
    output logic       locked,
    output logic       dir,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] turn_cnt,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ACQUIRE   = 2'd0,
        SYNC      = 2'd1,
        LOCK_UP   = 2'd2,
        LOCK_DOWN = 2'd3
    } state_t;

    localparam logic [1:0] CODE_NON_BCD = 2'b01;
    localparam logic [1:0] CODE_STEP    = 2'b10;
    localparam logic [1:0] CODE_DWELL   = 2'b11;

    state_t     state_q, state_d;
    logic [3:0] prev_q, prev_d;
    logic       locked_q, locked_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] turn_cnt_q, turn_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic is_bcd;
    logic up_step;
    logic down_step;
    logic dwell;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Step classification of the incoming sample relative to the last accepted one.
    always_comb begin
        is_bcd    = (count_in <= 4'd9);
        up_step   = (prev_q < 4'd9) && (count_in == prev_q + 4'd1);
        down_step = (prev_q != 4'd0) && (count_in == prev_q - 4'd1);
        dwell     = (count_in == prev_q);
    end

    // Next-state and registered-output computation; everything holds when valid_in is low.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        dir_d      = dir_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        turn_cnt_d = turn_cnt_q;
        err_cnt_d  = err_cnt_q;

        if (valid_in) begin
            if (!is_bcd) begin
                // Non-BCD always drops back to acquisition and keeps prev as is.
                err_d      = 1'b1;
                err_code_d = CODE_NON_BCD;
                state_d    = ACQUIRE;
            end else begin
                // Every BCD sample, even a rejected one, becomes the new resync point.
                prev_d = count_in;
                case (state_q)
                    ACQUIRE: begin
                        state_d = SYNC;
                    end
                    SYNC: begin
                        if (up_step || (dwell && prev_q == 4'd0)) begin
                            state_d = LOCK_UP;
                            dir_d   = 1'b0;
                        end else if (down_step || (dwell && prev_q == 4'd9)) begin
                            state_d = LOCK_DOWN;
                            dir_d   = 1'b1;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = dwell ? CODE_DWELL : CODE_STEP;
                        end
                    end
                    LOCK_UP: begin
                        if (up_step) begin
                            state_d = LOCK_UP;
                        end else if (prev_q == 4'd9 && count_in == 4'd9) begin
                            state_d    = LOCK_DOWN;
                            dir_d      = 1'b1;
                            turn_cnt_d = sat_inc(turn_cnt_q);
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = dwell ? CODE_DWELL : CODE_STEP;
                            state_d    = SYNC;
                        end
                    end
                    LOCK_DOWN: begin
                        if (down_step) begin
                            state_d = LOCK_DOWN;
                        end else if (prev_q == 4'd0 && count_in == 4'd0) begin
                            state_d    = LOCK_UP;
                            dir_d      = 1'b0;
                            turn_cnt_d = sat_inc(turn_cnt_q);
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = dwell ? CODE_DWELL : CODE_STEP;
                            state_d    = SYNC;
                        end
                    end
                    default: begin
                        state_d = ACQUIRE;
                    end
                endcase
            end

            if (err_d) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end

        locked_d = (state_d == LOCK_UP) || (state_d == LOCK_DOWN);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ACQUIRE;
            prev_q     <= 4'd0;
            locked_q   <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            turn_cnt_q <= 8'd0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            locked_q   <= locked_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            turn_cnt_q <= turn_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign locked   = locked_q;
    assign dir      = dir_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign turn_cnt = turn_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_bcd_sequence_monitor.sv
// Testbench for bcd_sequence_monitor: directed scenarios plus randomized
// stream, every output compared each step against a phase-based model of the
// 20-sample bouncing sequence.
module tb_bcd_sequence_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       valid_in;
    logic       locked;
    logic       dir;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] turn_cnt;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mode 0 = no reference, 1 = reference held but unlocked, 2 = locked.
    // When locked, m_phase is the position 0..19 in the legal period 0..9,9..0.
    int         m_mode;
    int         m_phase;
    int         m_ref;
    logic       m_dir;
    logic       m_err;
    logic [1:0] m_code;
    logic [7:0] m_turn;
    logic [7:0] m_errc;

    // Stimulus generator position in the legal period.
    int g;

    bcd_sequence_monitor dut (
        .clk      (clk),
        .reset    (reset),
        .count_in (count_in),
        .valid_in (valid_in),
        .locked   (locked),
        .dir      (dir),
        .err      (err),
        .err_code (err_code),
        .turn_cnt (turn_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int val(input int p);
        return (p < 10) ? p : 19 - p;
    endfunction

    function automatic logic [3:0] nxt();
        g = (g + 1) % 20;
        return 4'(val(g));
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_phase = 0;
        m_ref   = 0;
        m_dir   = 1'b0;
        m_err   = 1'b0;
        m_code  = 2'b00;
        m_turn  = 8'd0;
        m_errc  = 8'd0;
    endtask

    task automatic model_error(input logic [1:0] code);
        m_err  = 1'b1;
        m_code = code;
        if (m_errc != 8'd255) m_errc = m_errc + 8'd1;
    endtask

    task automatic model_update(input logic v, input logic [3:0] c);
        int ci;
        int q;
        int np;
        ci    = int'(c);
        m_err = 1'b0;
        if (!v) return;
        if (ci > 9) begin
            model_error(2'b01);
            m_mode = 0;
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            q = -1;
            if (ci == m_ref + 1) q = ci;
            else if (ci + 1 == m_ref) q = 19 - ci;
            else if (ci == m_ref && ci == 9) q = 10;
            else if (ci == m_ref && ci == 0) q = 0;
            if (q >= 0) begin
                m_mode  = 2;
                m_phase = q;
                m_dir   = (q >= 10);
            end else begin
                model_error((ci == m_ref) ? 2'b11 : 2'b10);
            end
        end else begin
            np = (m_phase + 1) % 20;
            if (ci == val(np)) begin
                if ((np == 0 || np == 10) && m_turn != 8'd255) m_turn = m_turn + 8'd1;
                m_phase = np;
                m_dir   = (np >= 10);
            end else begin
                model_error((ci == val(m_phase)) ? 2'b11 : 2'b10);
                m_mode = 1;
            end
        end
        m_ref = ci;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"},   8'(locked),   8'(m_mode == 2));
        chk({tag, ".dir"},      8'(dir),      8'(m_dir));
        chk({tag, ".err"},      8'(err),      8'(m_err));
        chk({tag, ".err_code"}, 8'(err_code), 8'(m_code));
        chk({tag, ".turn_cnt"}, turn_cnt,     m_turn);
        chk({tag, ".err_cnt"},  err_cnt,      m_errc);
    endtask

    task automatic step(input logic v, input logic [3:0] c);
        @(negedge clk);
        valid_in = v;
        count_in = c;
        @(posedge clk);
        model_update(v, c);
        #1;
        check_all("step");
    endtask

    task automatic reset_async();
        @(negedge clk);
        valid_in = 1'b1;
        count_in = 4'd5;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        reset    = 1'b0;
        valid_in = 1'b0;
    endtask

    initial begin
        int r;
        int guard;
        reset    = 1'b1;
        valid_in = 1'b0;
        count_in = 4'd0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset_init");
        @(negedge clk);
        reset = 1'b0;

        // Full legal bounce 0..9,9..0,0,1: two turnarounds, no errors.
        g = 19;
        step(1'b1, nxt());
        step(1'b1, nxt());
        chk("lock_after_2", 8'(locked), 8'd1);
        repeat (20) step(1'b1, nxt());
        chk("bounce_turn", turn_cnt, 8'd2);
        chk("bounce_errc", err_cnt, 8'd0);
        chk("bounce_dir", 8'(dir), 8'd0);

        // Wrong step while locked up at 5.
        repeat (4) step(1'b1, nxt());
        step(1'b1, 4'd7);
        chk("skip_err", 8'(err), 8'd1);
        chk("skip_code", 8'(err_code), 8'd2);
        chk("skip_locked", 8'(locked), 8'd0);
        step(1'b1, 4'd8);
        step(1'b1, 4'd9);
        chk("relock", 8'(locked), 8'd1);
        chk("relock_dir", 8'(dir), 8'd0);
        chk("relock_errc", err_cnt, 8'd1);

        // Triple 9: the third one is an illegal dwell.
        g = 9;
        repeat (19) step(1'b1, nxt());
        step(1'b1, 4'd9);
        step(1'b1, 4'd9);
        step(1'b1, 4'd9);
        chk("dwell_code", 8'(err_code), 8'd3);
        chk("dwell_locked", 8'(locked), 8'd0);
        step(1'b1, 4'd8);
        chk("dwell_relock", 8'(locked), 8'd1);
        chk("dwell_dir", 8'(dir), 8'd1);
        g = 11;

        // valid_in low for five cycles with garbage on count_in.
        repeat (5) step(1'b0, 4'($urandom_range(0, 15)));
        chk("gap_locked", 8'(locked), 8'd1);
        repeat (3) step(1'b1, nxt());
        chk("gap_errc", err_cnt, 8'd2);

        // Non-BCD while locked, then reacquire on 3,4.
        step(1'b1, 4'hC);
        chk("nonbcd_code", 8'(err_code), 8'd1);
        chk("nonbcd_locked", 8'(locked), 8'd0);
        step(1'b1, 4'd3);
        chk("acq_locked", 8'(locked), 8'd0);
        step(1'b1, 4'd4);
        chk("acq_relock", 8'(locked), 8'd1);
        chk("acq_dir", 8'(dir), 8'd0);
        g = 4;

        // Randomized stream: mostly legal, with gaps, bad digits and resets.
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 199);
            if (r < 20) step(1'b0, 4'($urandom_range(0, 15)));
            else if (r < 32) step(1'b1, 4'($urandom_range(0, 9)));
            else if (r < 36) step(1'b1, 4'($urandom_range(10, 15)));
            else if (r < 38) reset_async();
            else step(1'b1, nxt());
        end

        // Saturate turn_cnt with a long legal stream.
        reset_async();
        g = 19;
        guard = 0;
        while (m_turn != 8'd255 && guard < 3000) begin
            step(1'b1, nxt());
            guard++;
        end
        chk("sat_reached_in_budget", 8'(guard < 3000), 8'd1);
        repeat (25) step(1'b1, nxt());
        chk("turn_sat", turn_cnt, 8'd255);
        reset_async();
        chk("turn_after_rst", turn_cnt, 8'd0);
        chk("locked_after_rst", 8'(locked), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
